health_manager: RTL and testbench
=================================

// Module: health_manager
// PURPOSE
//  Per-player health tracker and on-screen bar renderer for N_PLAYERS. Every frame_clk tick it
//  sums valid bullet hits into damage, applies invulnerability frames, heal and regen, and
//  reports a sticky game-over naming the first player to die. Draw outputs feed the colour mapper.
// PARAMETERS
//  N_PLAYERS    2     players/bars tracked (1..4)
//  N_BULLETS    20    bullet slots in hit/bullet_state vectors
//  LEN_W        10    width of health, length and damage quantities
//  BAR_X0       10    left x of every bar (pixels)
//  BAR_Y0       10    top y of bar 0
//  BAR_H        40    bar height in pixels (rows BAR_Y0+p*BAR_PITCH .. +BAR_H inclusive)
//  BAR_PITCH    50    vertical spacing between bars
//  IFRAMES      30    frames of damage immunity after a damaging hit (0 = none)
//  REGEN_PERIOD 60    frames between +REGEN_AMT regen steps (0 = regen off)
//  REGEN_AMT    1     health restored per regen step
// PORTS
//  frame_clk    in   1                    clock, one tick per video frame
//  reset        in   1                    synchronous, active-high
//  hit          in   [N_PLAYERS][N_BULLETS] hit[p][b]: bullet b overlaps player p this frame
//  bullet_state in   [N_BULLETS][2]       2'b01/2'b10 = live bullet; 00/11 ignored
//  damage_unit  in   LEN_W                damage per valid hit
//  len_init     in   LEN_W                full health / full bar length, sampled at reset
//  heal_req     in   N_PLAYERS            one-frame heal pulse per player
//  heal_amt     in   LEN_W                health added per heal_req
//  DrawX, DrawY in   10 each              current pixel
//  is_healthbar out  1                    pixel lies inside some player's current bar
//  bar_id       out  2                    index of that bar (0 when is_healthbar=0)
//  health       out  [N_PLAYERS][LEN_W]   registered current health
//  gameover     out  1                    sticky: some player reached 0
//  loser_id     out  2                    first player to reach 0 (lowest index on tie)
// BEHAVIOUR
//  Reset: health[p]=len_init (captured into len_max), state=ALIVE, ifr/regen counters=0,
//   gameover=0, loser_id=0. Reset wins over all other inputs in the same tick.
//  Hit count: hits[p] = number of b with hit[p][b] && bullet_state[b] in {01,10}.
//   dmg[p] = hits[p]*damage_unit, computed at LEN_W+$clog2(N_BULLETS+1) bits, no truncation.
//  Per-player FSM, updated each tick (one-tick latency from inputs to health/state):
//   ALIVE : dmg>0 -> h' = sat0(h - dmg); if h'==0 -> DEAD else (IFRAMES>0 ? INVULN : ALIVE),
//           ifr=IFRAMES-1. Heal on same tick applied after damage, only if h'>0.
//   INVULN: dmg ignored; heal/regen allowed; ifr decrements; ifr==0 -> ALIVE next tick.
//   DEAD  : health held 0; heal, regen and damage ignored until reset.
//  Heal: h' = min(h' + heal_amt, len_max), computed one bit wider to avoid wrap.
//  Regen (ALIVE/INVULN, REGEN_PERIOD>0): counter counts frames since last step/damage; a damaging
//   hit clears it; at REGEN_PERIOD-1 -> h'=min(h'+REGEN_AMT,len_max), counter=0. Full health: counter held 0.
//  Order within a tick: damage -> heal -> regen -> clamp to [0,len_max].
//  gameover: set the tick any player enters DEAD; loser_id = lowest such p; both sticky until
//   reset (later deaths do not change loser_id).
//  Draw (combinational from registered health): bar p covers BAR_X0 <= DrawX < BAR_X0+health[p],
//   row window per BAR_H/BAR_PITCH; health 0 draws nothing. Overlap -> lowest p wins bar_id.
// STRUCTURE
//  health_pkg: typedef enum logic[1:0] {ALIVE,INVULN,DEAD} hp_state_t; bullet_live() function;
//   DMG_W localparam helper.
//  Sub-module health_channel (one per player via generate): hit count, FSM, counters, health reg.
//  Top: generate loop, gameover/loser priority encoder, pixel bar decode.
// TESTING
//  1 reset, len_init=100, damage_unit=5, 3 live hits on p0 -> next tick health[0]=85, INVULN.
//  2 p0 INVULN (IFRAMES=30): hits each frame for 29 ticks -> health stays 85; tick 31 hit -> 80.
//  3 health[1]=4, dmg=10 with heal_req same tick -> health 0, DEAD, gameover=1, loser_id=1, heal ignored.
//  4 p0,p1 die same tick -> loser_id=0; later heal_req / regen -> health stays 0, gameover stays 1.
//  5 health 98, heal_amt=10 -> 100 (clamped); REGEN_PERIOD=4 from 97 -> 98 after 4 idle ticks.
//  6 bullet_state=11 with hit set -> no damage; reset mid-INVULN -> health=len_init, ALIVE next tick.
//  7 draw: health[0]=50, DrawY=20: DrawX 59 -> is_healthbar=1, bar_id=0; DrawX 60 -> 0.

Source files
------------

// File: rtl/health_pkg.sv
// Shared types and helpers for the per-player health tracker and bar renderer.
package health_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hp_state_t;

  // Wide enough that every bullet slot hitting at the largest damage_unit cannot wrap.
  function automatic int dmg_width(input int len_w, input int n_bullets);
    return len_w + $clog2(n_bullets + 1);
  endfunction

  function automatic logic bullet_live(input logic [1:0] bstate);
    return (bstate == 2'b01) || (bstate == 2'b10);
  endfunction

endpackage

// File: rtl/health_channel.sv
// One player's health: live-hit count, damage/heal/regen datapath and ALIVE/INVULN/DEAD FSM.
module health_channel
  import health_pkg::*;
#(
  parameter int N_BULLETS    = 20,
  parameter int LEN_W        = 10,
  parameter int IFRAMES      = 30,
  parameter int REGEN_PERIOD = 60,
  parameter int REGEN_AMT    = 1
) (
  input  logic                      frame_clk,
  input  logic                      reset,
  input  logic [N_BULLETS-1:0]      hit,
  input  logic [N_BULLETS-1:0][1:0] bullet_state,
  input  logic [LEN_W-1:0]          damage_unit,
  input  logic [LEN_W-1:0]          len_init,
  input  logic                      heal_req,
  input  logic [LEN_W-1:0]          heal_amt,
  output logic [LEN_W-1:0]          health,
  output logic                      dying
);

  localparam int CNT_W = $clog2(N_BULLETS + 1);
  localparam int DMG_W = dmg_width(LEN_W, N_BULLETS);
  localparam int HW    = LEN_W + 1;
  localparam int IFR_W = (IFRAMES > 1) ? $clog2(IFRAMES) : 1;
  localparam int RGN_W = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;

  hp_state_t          state_reg, state_next;
  logic [LEN_W-1:0]   health_reg, health_next;
  logic [LEN_W-1:0]   len_max_reg;
  logic [IFR_W-1:0]   ifr_reg, ifr_next;
  logic [RGN_W-1:0]   regen_reg, regen_next;
  logic [N_BULLETS-1:0] live_hit;
  logic [CNT_W-1:0]   hit_cnt;
  logic [DMG_W-1:0]   dmg;
  logic [HW-1:0]      h_heal, h_regen;
  logic               took_dmg;

  for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_live
    assign live_hit[gi] = hit[gi] && bullet_live(bullet_state[gi]);
  end

  assign hit_cnt = CNT_W'($countones(live_hit));
  assign dmg     = DMG_W'(hit_cnt) * DMG_W'(damage_unit);

  always_ff @(posedge frame_clk) begin
    if (reset) begin
      state_reg   <= ALIVE;
      health_reg  <= len_init;
      len_max_reg <= len_init;
      ifr_reg     <= '0;
      regen_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      health_reg  <= health_next;
      ifr_reg     <= ifr_next;
      regen_reg   <= regen_next;
    end
  end

  // Damage first, then heal, then regen; heal/regen saturate at the captured full length.
  always_comb begin
    state_next  = state_reg;
    health_next = health_reg;
    ifr_next    = ifr_reg;
    regen_next  = regen_reg;
    took_dmg    = 1'b0;
    h_heal      = '0;
    h_regen     = '0;
    case (state_reg)
      ALIVE: begin
        if (dmg != '0) begin
          took_dmg    = 1'b1;
          health_next = (dmg >= DMG_W'(health_reg)) ? '0 : LEN_W'(DMG_W'(health_reg) - dmg);
          if (health_next == '0) begin
            state_next = DEAD;
          end else if (IFRAMES > 0) begin
            state_next = INVULN;
            ifr_next   = IFR_W'(IFRAMES - 1);
          end
        end
      end
      INVULN: begin
        if (ifr_reg <= IFR_W'(1)) begin
          state_next = ALIVE;
          ifr_next   = '0;
        end else begin
          ifr_next = ifr_reg - IFR_W'(1);
        end
      end
      DEAD:    health_next = '0;
      default: state_next = DEAD;
    endcase

    if (state_reg != DEAD && state_next != DEAD) begin
      if (heal_req) begin
        h_heal      = HW'(health_next) + HW'(heal_amt);
        health_next = (h_heal > HW'(len_max_reg)) ? len_max_reg : h_heal[LEN_W-1:0];
      end
      if (REGEN_PERIOD > 0) begin
        if (took_dmg || health_next >= len_max_reg) begin
          regen_next = '0;
        end else if (regen_reg == RGN_W'(REGEN_PERIOD - 1)) begin
          h_regen     = HW'(health_next) + HW'(REGEN_AMT);
          health_next = (h_regen > HW'(len_max_reg)) ? len_max_reg : h_regen[LEN_W-1:0];
          regen_next  = '0;
        end else begin
          regen_next = regen_reg + RGN_W'(1);
        end
      end
    end
  end

  always_comb begin
    health = health_reg;
    dying  = (state_next == DEAD) && (state_reg != DEAD);
  end

endmodule

// File: rtl/health_manager.sv
// Health tracker for N_PLAYERS: per-player channels, sticky game-over/loser and health-bar pixel decode.
module health_manager
  import health_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int N_BULLETS    = 20,
  parameter int LEN_W        = 10,
  parameter int BAR_X0       = 10,
  parameter int BAR_Y0       = 10,
  parameter int BAR_H        = 40,
  parameter int BAR_PITCH    = 50,
  parameter int IFRAMES      = 30,
  parameter int REGEN_PERIOD = 60,
  parameter int REGEN_AMT    = 1
) (
  input  logic                                frame_clk,
  input  logic                                reset,
  input  logic [N_PLAYERS-1:0][N_BULLETS-1:0] hit,
  input  logic [N_BULLETS-1:0][1:0]           bullet_state,
  input  logic [LEN_W-1:0]                    damage_unit,
  input  logic [LEN_W-1:0]                    len_init,
  input  logic [N_PLAYERS-1:0]                heal_req,
  input  logic [LEN_W-1:0]                    heal_amt,
  input  logic [9:0]                          DrawX,
  input  logic [9:0]                          DrawY,
  output logic                                is_healthbar,
  output logic [1:0]                          bar_id,
  output logic [N_PLAYERS-1:0][LEN_W-1:0]     health,
  output logic                                gameover,
  output logic [1:0]                          loser_id
);

  localparam int PX_W = ((LEN_W > 10) ? LEN_W : 10) + 2;

  logic [N_PLAYERS-1:0] dying;
  logic [N_PLAYERS-1:0] in_bar;
  logic [1:0]           first_dying;
  logic                 gameover_reg;
  logic [1:0]           loser_id_reg;
  logic [PX_W-1:0]      x_ext, y_ext;

  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
    health_channel #(
      .N_BULLETS    (N_BULLETS),
      .LEN_W        (LEN_W),
      .IFRAMES      (IFRAMES),
      .REGEN_PERIOD (REGEN_PERIOD),
      .REGEN_AMT    (REGEN_AMT)
    ) u_channel (
      .frame_clk    (frame_clk),
      .reset        (reset),
      .hit          (hit[gi]),
      .bullet_state (bullet_state),
      .damage_unit  (damage_unit),
      .len_init     (len_init),
      .heal_req     (heal_req[gi]),
      .heal_amt     (heal_amt),
      .health       (health[gi]),
      .dying        (dying[gi])
    );
  end

  always_comb begin
    first_dying = '0;
    for (int p = N_PLAYERS - 1; p >= 0; p--) begin
      if (dying[p]) first_dying = 2'(p);
    end
  end

  // Only the first death latches; later deaths leave loser_id alone.
  always_ff @(posedge frame_clk) begin
    if (reset) begin
      gameover_reg <= 1'b0;
      loser_id_reg <= '0;
    end else if (!gameover_reg && (|dying)) begin
      gameover_reg <= 1'b1;
      loser_id_reg <= first_dying;
    end
  end

  assign gameover = gameover_reg;
  assign loser_id = loser_id_reg;

  assign x_ext = PX_W'(DrawX);
  assign y_ext = PX_W'(DrawY);

  // Bar rows are inclusive at both ends; an empty bar (health 0) has x_end == BAR_X0.
  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_bar
    localparam int Y_TOP = BAR_Y0 + gi * BAR_PITCH;
    logic [PX_W-1:0] x_end;
    assign x_end      = PX_W'(BAR_X0) + PX_W'(health[gi]);
    assign in_bar[gi] = (x_ext >= PX_W'(BAR_X0)) && (x_ext < x_end) &&
                        (y_ext >= PX_W'(Y_TOP)) && (y_ext <= PX_W'(Y_TOP + BAR_H));
  end

  always_comb begin
    bar_id = '0;
    for (int p = N_PLAYERS - 1; p >= 0; p--) begin
      if (in_bar[p]) bar_id = 2'(p);
    end
  end

  assign is_healthbar = |in_bar;

endmodule

// File: tb/tb_health_manager.sv
// Scoreboard bench: two health_manager instances (iframes-only and regen-only) against a reference model.
module tb_health_manager;

  localparam int NP = 2;
  localparam int NB = 20;
  localparam int LW = 10;
  localparam int ST_ALIVE = 0;
  localparam int ST_INV   = 1;
  localparam int ST_DEAD  = 2;

  logic                   frame_clk = 1'b0;
  logic                   reset;
  logic [NP-1:0][NB-1:0]  hit;
  logic [NB-1:0][1:0]     bullet_state;
  logic [LW-1:0]          damage_unit, len_init, heal_amt;
  logic [NP-1:0]          heal_req;
  logic [9:0]             draw_x, draw_y;
  logic                   is_hb_a, is_hb_b, go_a, go_b;
  logic [1:0]             bar_id_a, bar_id_b, loser_a, loser_b;
  logic [NP-1:0][LW-1:0]  health_a, health_b;

  typedef struct {
    int d;
    int h0;
    int h1;
    int go;
    int lo;
  } exp_t;

  exp_t sb_q[$];
  int   m_h[2][NP], m_st[2][NP], m_ifr[2][NP], m_rc[2][NP];
  int   m_max[2], m_go[2], m_lo[2];
  int   tests_run, tests_failed, frame_no;

  always #5 frame_clk = ~frame_clk;

  health_manager #(.N_PLAYERS(NP), .N_BULLETS(NB), .LEN_W(LW), .IFRAMES(30), .REGEN_PERIOD(0)) dut_a (
    .frame_clk(frame_clk), .reset(reset), .hit(hit), .bullet_state(bullet_state),
    .damage_unit(damage_unit), .len_init(len_init), .heal_req(heal_req), .heal_amt(heal_amt),
    .DrawX(draw_x), .DrawY(draw_y), .is_healthbar(is_hb_a), .bar_id(bar_id_a),
    .health(health_a), .gameover(go_a), .loser_id(loser_a)
  );

  health_manager #(.N_PLAYERS(NP), .N_BULLETS(NB), .LEN_W(LW), .IFRAMES(0), .REGEN_PERIOD(4)) dut_b (
    .frame_clk(frame_clk), .reset(reset), .hit(hit), .bullet_state(bullet_state),
    .damage_unit(damage_unit), .len_init(len_init), .heal_req(heal_req), .heal_amt(heal_amt),
    .DrawX(draw_x), .DrawY(draw_y), .is_healthbar(is_hb_b), .bar_id(bar_id_b),
    .health(health_b), .gameover(go_b), .loser_id(loser_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input int expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int count_hits(input int p);
    int n = 0;
    for (int b = 0; b < NB; b++) begin
      if (hit[p][b] && (bullet_state[b] == 2'b01 || bullet_state[b] == 2'b10)) n++;
    end
    return n;
  endfunction

  function automatic int sat_max(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input int d, input int ifrm, input int rp, input bit rst);
    int  h, dm, died;
    bit  dmgd;
    died = -1;
    if (rst) begin
      m_max[d] = int'(len_init);
      m_go[d]  = 0;
      m_lo[d]  = 0;
      for (int p = 0; p < NP; p++) begin
        m_h[d][p] = int'(len_init); m_st[d][p] = ST_ALIVE; m_ifr[d][p] = 0; m_rc[d][p] = 0;
      end
      return;
    end
    for (int p = 0; p < NP; p++) begin
      if (m_st[d][p] == ST_DEAD) continue;
      h    = m_h[d][p];
      dmgd = 1'b0;
      dm   = count_hits(p) * int'(damage_unit);
      if (m_st[d][p] == ST_ALIVE) begin
        if (dm > 0) begin
          dmgd = 1'b1;
          h = (dm >= h) ? 0 : h - dm;
          if (h == 0) begin
            m_st[d][p] = ST_DEAD;
            m_h[d][p]  = 0;
            if (died < 0) died = p;
            continue;
          end
          if (ifrm > 0) begin
            m_st[d][p]  = ST_INV;
            m_ifr[d][p] = ifrm - 1;
          end
        end
      end else if (m_ifr[d][p] <= 1) begin
        m_st[d][p]  = ST_ALIVE;
        m_ifr[d][p] = 0;
      end else begin
        m_ifr[d][p]--;
      end
      if (heal_req[p]) h = sat_max(h + int'(heal_amt), m_max[d]);
      if (rp > 0) begin
        if (dmgd || h >= m_max[d]) m_rc[d][p] = 0;
        else if (m_rc[d][p] == rp - 1) begin
          h = sat_max(h + 1, m_max[d]);
          m_rc[d][p] = 0;
        end else m_rc[d][p]++;
      end
      m_h[d][p] = h;
    end
    if (m_go[d] == 0 && died >= 0) begin
      m_go[d] = 1;
      m_lo[d] = died;
    end
  endtask

  task automatic step(input bit rst);
    exp_t e;
    reset = rst;
    for (int d = 0; d < 2; d++) begin
      model_step(d, (d == 0) ? 30 : 0, (d == 0) ? 0 : 4, rst);
      e.d = d; e.h0 = m_h[d][0]; e.h1 = m_h[d][1]; e.go = m_go[d]; e.lo = m_lo[d];
      sb_q.push_back(e);
    end
    @(posedge frame_clk);
    #1;
    frame_no++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.d == 0) begin
        check_val("sb_a_h0", health_a[0], e.h0);
        check_val("sb_a_h1", health_a[1], e.h1);
        check_val("sb_a_go", go_a, e.go);
        check_val("sb_a_lo", loser_a, e.lo);
      end else begin
        check_val("sb_b_h0", health_b[0], e.h0);
        check_val("sb_b_h1", health_b[1], e.h1);
        check_val("sb_b_go", go_b, e.go);
        check_val("sb_b_lo", loser_b, e.lo);
      end
    end
    $display("[TB] frame %0d rst=%0b A h=%0d,%0d go=%0b lo=%0d | B h=%0d,%0d go=%0b lo=%0d",
             frame_no, rst, health_a[0], health_a[1], go_a, loser_a,
             health_b[0], health_b[1], go_b, loser_b);
  endtask

  task automatic clear_inputs();
    hit = '0;
    heal_req = '0;
    for (int b = 0; b < NB; b++) bullet_state[b] = 2'b01;
  endtask

  task automatic check_draw(input int x, input int y, input int exp_hb, input int exp_id);
    draw_x = 10'(x);
    draw_y = 10'(y);
    step(1'b0);
    check_val($sformatf("draw_hb_%0d_%0d", x, y), is_hb_a, exp_hb);
    check_val($sformatf("draw_id_%0d_%0d", x, y), bar_id_a, exp_id);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; frame_no = 0;
    reset = 1'b1; heal_amt = '0; damage_unit = 10'd5; len_init = 10'd100;
    draw_x = '0; draw_y = '0;
    clear_inputs();

    // reset state, then three live hits plus two ignored slots (11 and 00)
    step(1'b1);
    check_val("reset_h0", health_a[0], 100);
    check_val("reset_go", go_a, 0);
    check_val("reset_lo", loser_a, 0);
    bullet_state[1] = 2'b10; bullet_state[3] = 2'b11; bullet_state[4] = 2'b00;
    for (int b = 0; b < 5; b++) hit[0][b] = 1'b1;
    step(1'b0);
    check_val("t1_h0", health_a[0], 85);

    // invulnerability window, then the first hit that lands again
    clear_inputs();
    hit[0][0] = 1'b1;
    repeat (29) step(1'b0);
    check_val("t2_invuln", health_a[0], 85);
    step(1'b0);
    check_val("t2_after", health_a[0], 80);

    // reset mid-INVULN with a hit present, dead bullet encoding, then damage lands at once
    step(1'b1);
    check_val("t6_reset_h0", health_a[0], 100);
    bullet_state[0] = 2'b11;
    step(1'b0);
    check_val("t6_bs11", health_a[0], 100);
    bullet_state[0] = 2'b01;
    step(1'b0);
    check_val("t6_alive", health_a[0], 95);

    // p1 down to 4, then lethal hit with a same-tick heal
    clear_inputs();
    step(1'b1);
    damage_unit = 10'd96; hit[1][0] = 1'b1;
    step(1'b0);
    check_val("t3_h1_4", health_a[1], 4);
    clear_inputs();
    repeat (30) step(1'b0);
    damage_unit = 10'd10; heal_amt = 10'd10; hit[1][0] = 1'b1; heal_req[1] = 1'b1;
    step(1'b0);
    check_val("t3_h1_dead", health_a[1], 0);
    check_val("t3_go", go_a, 1);
    check_val("t3_lo", loser_a, 1);

    // later death keeps loser; simultaneous deaths pick the lowest index
    clear_inputs();
    damage_unit = 10'd100; hit[0][0] = 1'b1; hit[1][0] = 1'b1;
    step(1'b0);
    check_val("t4_sticky_lo", loser_a, 1);
    check_val("t4_tie_go", go_b, 1);
    check_val("t4_tie_lo", loser_b, 0);
    clear_inputs();
    heal_req = '1;
    repeat (6) step(1'b0);
    check_val("t4_dead_h0_b", health_b[0], 0);
    check_val("t4_dead_h1_b", health_b[1], 0);
    check_val("t4_go_hold", go_b, 1);
    clear_inputs();
    check_draw(10, 20, 0, 0);

    // 20 hits x 52 = 1040 must not wrap in the damage sum
    step(1'b1);
    damage_unit = 10'd52; hit[0] = '1;
    step(1'b0);
    check_val("dmg_no_trunc", health_a[0], 0);
    check_val("dmg_no_trunc_go", go_a, 1);

    // heal clamp and regen
    clear_inputs();
    step(1'b1);
    damage_unit = 10'd2; hit[0][0] = 1'b1;
    step(1'b0);
    check_val("t5_98", health_b[0], 98);
    clear_inputs();
    heal_amt = 10'd10; heal_req[0] = 1'b1;
    step(1'b0);
    check_val("t5_heal_a", health_a[0], 100);
    check_val("t5_heal_b", health_b[0], 100);
    clear_inputs();
    damage_unit = 10'd3; hit[0][0] = 1'b1;
    step(1'b0);
    check_val("t5_97", health_b[0], 97);
    check_val("t5_invuln_a", health_a[0], 100);
    clear_inputs();
    repeat (3) step(1'b0);
    check_val("t5_regen_wait", health_b[0], 97);
    step(1'b0);
    check_val("t5_regen_98", health_b[0], 98);

    // draw decode
    step(1'b1);
    damage_unit = 10'd50; hit[0][0] = 1'b1;
    step(1'b0);
    check_val("t7_h0_50", health_a[0], 50);
    clear_inputs();
    check_draw(59, 20, 1, 0);
    check_draw(60, 20, 0, 0);
    check_draw(10, 10, 1, 0);
    check_draw(9, 20, 0, 0);
    check_draw(30, 50, 1, 0);
    check_draw(30, 51, 0, 0);
    check_draw(109, 70, 1, 1);
    check_draw(110, 70, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
